iob_ila_capture_core: RTL and testbench
=======================================

Name: iob_ila_capture_core

Overview:
Next-generation ILA capture engine with a programmable pre-trigger window over a circular sample buffer. It supports multi-channel triggering with per-channel level/edge type, negation and mask, plus an OR/AND combine mode. It runs on a single system clock with a sample-enable qualifier, and exposes a relative-index read port for software readout. It sits below the ILA register file, which drives its configuration and read ports.

Parameters:
SIGNAL_W, 32, width of the sampled signal vector.
DATA_W, 32, width of the read data word.
BUFFER_W, 8, log2 of buffer depth; DEPTH = 2**BUFFER_W.
TRIGGER_W, 4, number of trigger channels.
SEL_W, derived, max(1, clog2(ceil(SIGNAL_W/DATA_W))); word-select width. Not user-set.

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  synchronous reset, active low
cke_i  in  1  clock enable; low freezes all state and outputs
sample_en_i  in  1  sample qualifier; one sample taken per high cycle
signal_i  in  SIGNAL_W  data to capture
trigger_i  in  TRIGGER_W  trigger inputs
trig_type_i  in  TRIGGER_W  per channel: 1 = rising edge, 0 = level
trig_negate_i  in  TRIGGER_W  per channel: invert the input before detection
trig_mask_i  in  TRIGGER_W  per channel: 1 = channel participates
trig_mode_i  in  1  0 = OR of channels, 1 = AND of channels
pretrig_i  in  BUFFER_W  pre-trigger sample count; latched on arm
arm_i  in  1  start-capture pulse
abort_i  in  1  abort pulse
state_o  out  3  FSM state: 0 IDLE, 1 PRE, 2 WAIT, 3 POST, 4 DONE
triggered_o  out  1  one-cycle pulse on the trigger event
done_o  out  1  high while in DONE
n_samples_o  out  BUFFER_W+1  valid sample count, saturates at DEPTH
rd_en_i  in  1  read request
rd_addr_i  in  BUFFER_W  index relative to the oldest valid sample
rd_sel_i  in  SEL_W  DATA_W word select within a sample
rd_data_o  out  DATA_W  read data
rd_valid_o  out  1  read data valid

Behaviour:
- Reset (rst_n_i low at a clk_i edge, cke_i ignored): state IDLE; wr_ptr, fill and trigger history cleared. All outputs are 0: state_o, triggered_o, done_o, n_samples_o, rd_data_o, rd_valid_o.
- A "sample" is any cycle with cke_i=1, sample_en_i=1, and state PRE, WAIT or POST. On a sample: mem[wr_ptr] <= signal_i; wr_ptr increments mod DEPTH; fill increments, saturating at DEPTH.
- Trigger evaluation happens only on sample cycles:
  - t = trigger_i ^ trig_negate_i.
  - hit[c] = trig_type_i[c] ? (t[c] & ~t_prev[c]) : t[c].
  - t_prev updates on every sample cycle and is cleared on arm.
  - OR mode: event = |(hit & mask).
  - AND mode: event = &(hit | ~mask) & |mask.
  - Mask = 0 never triggers in either mode.
- IDLE or DONE + arm_i:
  - Clear fill, wr_ptr and t_prev; latch pretrig_i.
  - Go to PRE if pretrig is nonzero, else WAIT.
- arm_i in PRE, WAIT or POST is ignored.
- PRE: sample normally; triggers are ignored. When fill reaches pretrig (on that sample), go to WAIT.
- WAIT: sample circularly. On a trigger event:
  - The triggering sample is written.
  - triggered_o pulses in the following cycle.
  - post_cnt is loaded with DEPTH - pretrig - 1, counting remaining samples.
  - Go to POST, or straight to DONE if post_cnt = 0.
- POST: each sample decrements post_cnt. The sample taken at post_cnt = 0 moves the FSM to DONE. At DONE, fill = DEPTH and the trigger sample sits at relative index pretrig.
- DONE: no writes. Stays in DONE until arm or abort.
- abort_i in any state → IDLE. fill and buffer contents are preserved. abort_i wins over arm_i in the same cycle.
- Read port:
  - Physical address = (fill == DEPTH ? wr_ptr : 0) + rd_addr_i, mod DEPTH.
  - rd_data_o = DATA_W slice rd_sel_i of that sample, zero-extended past SIGNAL_W.
  - Latency 1: rd_valid_o is high for exactly the cycle after rd_en_i. rd_data_o holds its value otherwise.
  - Reads are legal in any state. A read and a write to the same entry in the same cycle returns the old data.
  - rd_addr_i >= fill returns stale contents; this is not an error.
- n_samples_o = fill, registered.

Test Plan:
- Reset: drive random inputs with rst_n_i=0 for 3 cycles → all outputs 0, state_o=0. Reset mid-POST → IDLE and n_samples_o=0 next cycle.
- BUFFER_W=4, pretrig=4, OR mode, level trigger, mask=0001, signal_i=sample counter, trigger[0] high at sample 20 → done_o rises after sample 31. Reads return idx0=16, idx4=20, idx15=31; n_samples_o=16.
- Edge vs negate: trigger[0] held at 1, type=edge → no trigger. Negate=1 with a 1→0 transition → triggers on that sample. Level with negate=1 and input 0 → triggers on the first WAIT sample.
- AND mode, mask=0011: only ch0 high → no trigger; ch0 and ch1 high → trigger. Mask=0000 in either mode → remains in WAIT.
- Trigger held high throughout PRE (pretrig=4) → ignored until fill=4, then triggers on sample 5 (index 4). sample_en_i gaps do not advance fill. pretrig=0 → arm goes straight to WAIT.
- abort_i in POST → IDLE, n_samples_o kept. arm_i+abort_i together → IDLE. SIGNAL_W=40, DATA_W=32, rd_sel_i=1 → upper 8 bits, zero-extended; rd_valid_o one cycle after rd_en_i.

Source files
------------

// File: rtl/iob_ila_capture_core_if.sv
// rtl/iob_ila_capture_core_if.sv - read port bundle between the ILA register file and the capture core
interface iob_ila_capture_core_if #(
    parameter int SIGNAL_W = 32,
    parameter int DATA_W   = 32,
    parameter int BUFFER_W = 8
);
    localparam int N_WORDS = (SIGNAL_W + DATA_W - 1) / DATA_W;
    localparam int SEL_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

    logic                rd_en_i;
    logic [BUFFER_W-1:0] rd_addr_i;
    logic [SEL_W-1:0]    rd_sel_i;
    logic [DATA_W-1:0]   rd_data_o;
    logic                rd_valid_o;

    modport master (
        output rd_en_i, rd_addr_i, rd_sel_i,
        input  rd_data_o, rd_valid_o
    );

    modport slave (
        input  rd_en_i, rd_addr_i, rd_sel_i,
        output rd_data_o, rd_valid_o
    );
endinterface

// File: rtl/iob_ila_capture_core.sv
// rtl/iob_ila_capture_core.sv - ILA capture engine: circular buffer, pre-trigger window, multi-channel trigger
module iob_ila_capture_core #(
    parameter int SIGNAL_W  = 32,
    parameter int DATA_W    = 32,
    parameter int BUFFER_W  = 8,
    parameter int TRIGGER_W = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 cke_i,
    input  logic                 sample_en_i,
    input  logic [SIGNAL_W-1:0]  signal_i,
    input  logic [TRIGGER_W-1:0] trigger_i,
    input  logic [TRIGGER_W-1:0] trig_type_i,
    input  logic [TRIGGER_W-1:0] trig_negate_i,
    input  logic [TRIGGER_W-1:0] trig_mask_i,
    input  logic                 trig_mode_i,
    input  logic [BUFFER_W-1:0]  pretrig_i,
    input  logic                 arm_i,
    input  logic                 abort_i,
    output logic [2:0]           state_o,
    output logic                 triggered_o,
    output logic                 done_o,
    output logic [BUFFER_W:0]    n_samples_o,
    iob_ila_capture_core_if.slave rd_if
);
    localparam int DEPTH   = 2 ** BUFFER_W;
    localparam int N_WORDS = (SIGNAL_W + DATA_W - 1) / DATA_W;
    localparam int SEL_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int PAD_W   = DATA_W * (2 ** SEL_W);
    localparam logic [BUFFER_W:0] FULL = (BUFFER_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [BUFFER_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [BUFFER_W:0]    fill_q, fill_d;
    logic [TRIGGER_W-1:0] t_prev_q, t_prev_d;
    logic [BUFFER_W-1:0]  pretrig_q, pretrig_d;
    logic [BUFFER_W-1:0]  post_cnt_q, post_cnt_d;
    logic                 triggered_q, triggered_d;
    logic [DATA_W-1:0]    rd_data_q, rd_data_d;
    logic                 rd_valid_q, rd_valid_d;

    logic [SIGNAL_W-1:0]  mem_q [DEPTH];

    logic                 sample_w;
    logic [BUFFER_W:0]    fill_inc_w;
    logic [TRIGGER_W-1:0] t_w;
    logic [TRIGGER_W-1:0] hit_w;
    logic                 trig_ev_w;
    logic [BUFFER_W-1:0]  rd_phys_w;
    logic [PAD_W-1:0]     rd_padded_w;
    logic [(2**SEL_W)-1:0][DATA_W-1:0] rd_words_w;

    assign sample_w = cke_i && sample_en_i &&
                      ((state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST));
    assign fill_inc_w = (fill_q == FULL) ? fill_q : fill_q + 1'b1;

    // Edge channels compare against the previous sample's (negated) input, not the previous clock.
    always_comb begin
        t_w       = trigger_i ^ trig_negate_i;
        hit_w     = (trig_type_i & t_w & ~t_prev_q) | (~trig_type_i & t_w);
        trig_ev_w = trig_mode_i ? ((&(hit_w | ~trig_mask_i)) & (|trig_mask_i))
                                : (|(hit_w & trig_mask_i));
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        t_prev_d    = t_prev_q;
        pretrig_d   = pretrig_q;
        post_cnt_d  = post_cnt_q;
        triggered_d = triggered_q;
        if (cke_i) begin
            triggered_d = 1'b0;
            if (sample_w) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                fill_d   = fill_inc_w;
                t_prev_d = t_w;
            end
            if (abort_i) begin
                state_d = S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE, S_DONE: begin
                        if (arm_i) begin
                            state_d   = (pretrig_i != '0) ? S_PRE : S_WAIT;
                            fill_d    = '0;
                            wr_ptr_d  = '0;
                            t_prev_d  = '0;
                            pretrig_d = pretrig_i;
                        end
                    end
                    S_PRE: begin
                        if (sample_en_i && (fill_inc_w == {1'b0, pretrig_q})) begin
                            state_d = S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        // Remaining post samples: DEPTH - pretrig - 1, which is ~pretrig.
                        if (sample_en_i && trig_ev_w) begin
                            triggered_d = 1'b1;
                            post_cnt_d  = ~pretrig_q;
                            state_d     = (pretrig_q == '1) ? S_DONE : S_POST;
                        end
                    end
                    S_POST: begin
                        if (sample_en_i) begin
                            post_cnt_d = post_cnt_q - 1'b1;
                            if (post_cnt_q == BUFFER_W'(1)) begin
                                state_d = S_DONE;
                            end
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    // Once the buffer has wrapped, the oldest sample sits at the write pointer.
    always_comb begin
        rd_phys_w   = ((fill_q == FULL) ? wr_ptr_q : '0) + rd_if.rd_addr_i;
        rd_padded_w = PAD_W'(mem_q[rd_phys_w]);
        rd_words_w  = rd_padded_w;
        rd_valid_d  = cke_i ? rd_if.rd_en_i : rd_valid_q;
        rd_data_d   = (cke_i && rd_if.rd_en_i) ? rd_words_w[rd_if.rd_sel_i] : rd_data_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            t_prev_q    <= '0;
            pretrig_q   <= '0;
            post_cnt_q  <= '0;
            triggered_q <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            t_prev_q    <= t_prev_d;
            pretrig_q   <= pretrig_d;
            post_cnt_q  <= post_cnt_d;
            triggered_q <= triggered_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_n_i && sample_w) begin
            mem_q[wr_ptr_q] <= signal_i;
        end
    end

    assign state_o          = state_q;
    assign triggered_o      = triggered_q;
    assign done_o           = (state_q == S_DONE);
    assign n_samples_o      = fill_q;
    assign rd_if.rd_data_o  = rd_data_q;
    assign rd_if.rd_valid_o = rd_valid_q;
endmodule

// File: tb/tb_iob_ila_capture_core.sv
// tb/tb_iob_ila_capture_core.sv - scoreboard bench for the ILA capture core (40-bit samples, 16-deep buffer)
module tb_iob_ila_capture_core;
    localparam int SIGNAL_W  = 40;
    localparam int DATA_W    = 32;
    localparam int BUFFER_W  = 4;
    localparam int TRIGGER_W = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 cke;
    logic                 sample_en;
    logic [SIGNAL_W-1:0]  signal;
    logic [TRIGGER_W-1:0] trigger;
    logic [TRIGGER_W-1:0] trig_type;
    logic [TRIGGER_W-1:0] trig_negate;
    logic [TRIGGER_W-1:0] trig_mask;
    logic                 trig_mode;
    logic [BUFFER_W-1:0]  pretrig;
    logic                 arm;
    logic                 abort;
    logic [2:0]           state;
    logic                 triggered;
    logic                 done;
    logic [BUFFER_W:0]    n_samples;

    int n_tests = 0;
    int n_fail  = 0;
    int scnt    = 0;
    logic [DATA_W-1:0] exp_q [$];

    iob_ila_capture_core_if #(.SIGNAL_W(SIGNAL_W), .DATA_W(DATA_W), .BUFFER_W(BUFFER_W)) rd_if ();

    iob_ila_capture_core #(
        .SIGNAL_W(SIGNAL_W), .DATA_W(DATA_W), .BUFFER_W(BUFFER_W), .TRIGGER_W(TRIGGER_W)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .cke_i(cke), .sample_en_i(sample_en),
        .signal_i(signal), .trigger_i(trigger), .trig_type_i(trig_type),
        .trig_negate_i(trig_negate), .trig_mask_i(trig_mask), .trig_mode_i(trig_mode),
        .pretrig_i(pretrig), .arm_i(arm), .abort_i(abort),
        .state_o(state), .triggered_o(triggered), .done_o(done), .n_samples_o(n_samples),
        .rd_if(rd_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sample n carries n in the low word and n+0x80 in the upper 8 bits.
    function automatic logic [SIGNAL_W-1:0] sig(input int n);
        logic [7:0]  hi;
        logic [31:0] lo;
        hi = 8'(n + 128);
        lo = 32'(n);
        return {hi, lo};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp(input logic [TRIGGER_W-1:0] trg);
        sample_en = 1'b1;
        signal    = sig(scnt);
        trigger   = trg;
        tick();
        sample_en = 1'b0;
        scnt++;
    endtask

    task automatic do_arm(input logic [BUFFER_W-1:0] p);
        arm     = 1'b1;
        pretrig = p;
        tick();
        arm     = 1'b0;
        scnt    = 0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic cfg(input logic [3:0] ty, input logic [3:0] ng, input logic [3:0] mk, input logic md);
        trig_type   = ty;
        trig_negate = ng;
        trig_mask   = mk;
        trig_mode   = md;
    endtask

    task automatic rd(input logic [BUFFER_W-1:0] a, input logic s, input logic [DATA_W-1:0] exp);
        exp_q.push_back(exp);
        rd_if.rd_en_i   = 1'b1;
        rd_if.rd_addr_i = a;
        rd_if.rd_sel_i  = s;
        tick();
        rd_if.rd_en_i   = 1'b0;
        chk("rd_valid_rise", rd_if.rd_valid_o, 1);
        tick();
        chk("rd_valid_fall", rd_if.rd_valid_o, 0);
    endtask

    always @(posedge clk) begin
        #2;
        if (rd_if.rd_valid_o) begin
            if (exp_q.size() == 0) chk("rd_unexpected", 1, 0);
            else chk("rd_data", rd_if.rd_data_o, exp_q.pop_front());
        end
    end

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cke = 1'($urandom); sample_en = 1'($urandom); signal = {8'($urandom), 32'($urandom)};
            trigger = 4'($urandom); trig_type = 4'($urandom); trig_negate = 4'($urandom);
            trig_mask = 4'($urandom); trig_mode = 1'($urandom); pretrig = 4'($urandom);
            arm = 1'($urandom); abort = 1'($urandom);
            rd_if.rd_en_i = 1'($urandom); rd_if.rd_addr_i = 4'($urandom); rd_if.rd_sel_i = 1'($urandom);
            tick();
        end
        chk("rst_state", state, 0);
        chk("rst_triggered", triggered, 0);
        chk("rst_done", done, 0);
        chk("rst_n_samples", n_samples, 0);
        chk("rst_rd_data", rd_if.rd_data_o, 0);
        chk("rst_rd_valid", rd_if.rd_valid_o, 0);
        cke = 1'b1; sample_en = 1'b0; trigger = '0; arm = 1'b0; abort = 1'b0; pretrig = '0;
        rd_if.rd_en_i = 1'b0; rd_if.rd_addr_i = '0; rd_if.rd_sel_i = '0;
        cfg(4'b0000, 4'b0000, 4'b0001, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        // Basic capture: level trigger on ch0 at sample 20, pretrig 4
        do_arm(4);
        chk("arm_pre", state, 1);
        tick(); tick();
        chk("gap_no_fill", n_samples, 0);
        cke = 1'b0; sample_en = 1'b1; tick(); sample_en = 1'b0; cke = 1'b1;
        chk("cke_freeze", n_samples, 0);
        for (int i = 0; i < 20; i++) begin
            smp(4'b0000);
            if (i == 3) chk("pre_to_wait", state, 2);
        end
        chk("wait_saturated", n_samples, 16);
        smp(4'b0001);
        chk("trig_pulse", triggered, 1);
        chk("trig_post", state, 3);
        smp(4'b0000);
        chk("trig_pulse_end", triggered, 0);
        for (int i = 22; i < 32; i++) begin
            smp(4'b0000);
            if (i == 30) chk("post_before_last", state, 3);
        end
        chk("done_state", state, 4);
        chk("done_flag", done, 1);
        chk("done_fill", n_samples, 16);
        rd(0, 0, 32'd16);
        rd(4, 0, 32'd20);
        rd(15, 0, 32'd31);
        rd(4, 1, 32'h94);
        rd(15, 1, 32'h9f);
        smp(4'b0000);
        chk("done_no_write_fill", n_samples, 16);
        rd(0, 0, 32'd16);

        arm = 1'b1; abort = 1'b1; tick(); arm = 1'b0; abort = 1'b0;
        chk("arm_abort_idle", state, 0);
        chk("arm_abort_fill", n_samples, 16);

        // Trigger held high during PRE fires on the first WAIT sample
        cfg(4'b0000, 4'b0000, 4'b0001, 1'b0);
        do_arm(4);
        for (int i = 0; i < 4; i++) smp(4'b0001);
        chk("pre_ignore_state", state, 2);
        chk("pre_ignore_trig", triggered, 0);
        smp(4'b0001);
        chk("held_trig", triggered, 1);
        for (int i = 0; i < 11; i++) smp(4'b0000);
        chk("held_done", done, 1);
        rd(4, 0, 32'd4);
        rd(0, 0, 32'd0);

        // Edge type with held input, then negated falling input
        cfg(4'b0001, 4'b0000, 4'b0001, 1'b0);
        do_arm(4);
        for (int i = 0; i < 8; i++) smp(4'b0001);
        chk("edge_held_none", state, 2);
        trig_negate = 4'b0001;
        smp(4'b0001);
        chk("edge_neg_high", state, 2);
        smp(4'b0000);
        chk("edge_neg_fall_trig", triggered, 1);
        chk("edge_neg_post", state, 3);
        smp(4'b0000);
        do_abort();
        chk("abort_post_idle", state, 0);
        chk("abort_keeps_fill", n_samples, 11);
        rd(0, 0, 32'd0);
        rd(10, 0, 32'd10);

        // Level negate with pretrig 0, then reset while in POST
        cfg(4'b0000, 4'b0001, 4'b0001, 1'b0);
        do_arm(0);
        chk("pretrig0_wait", state, 2);
        smp(4'b0000);
        chk("lvl_neg_trig", triggered, 1);
        chk("lvl_neg_post", state, 3);
        smp(4'b0000);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("midpost_rst_state", state, 0);
        chk("midpost_rst_fill", n_samples, 0);
        chk("midpost_rst_rd_data", rd_if.rd_data_o, 0);

        // AND mode over ch0/ch1; arm while waiting is ignored
        cfg(4'b0000, 4'b0000, 4'b0011, 1'b1);
        do_arm(0);
        smp(4'b0001);
        chk("and_partial", state, 2);
        arm = 1'b1; pretrig = 4; tick(); arm = 1'b0;
        chk("arm_in_wait_state", state, 2);
        chk("arm_in_wait_fill", n_samples, 1);
        smp(4'b0011);
        chk("and_full", state, 3);
        do_abort();

        // Empty mask never triggers
        cfg(4'b0000, 4'b0000, 4'b0000, 1'b0);
        do_arm(0);
        smp(4'b1111);
        chk("mask0_or", state, 2);
        trig_mode = 1'b1;
        smp(4'b1111);
        chk("mask0_and", state, 2);
        do_abort();

        tick();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
